pe_id_scan_gen: RTL and testbench

Sequential, parametrised PE-array ID generator. It latches one layer-mapping configuration, walks the physical PE array row-major, and streams one ID record per PE over a valid/ready port into the GLB-to-PE multicast-controller ID loader. It replaces fixed-size combinational ID arrays with counter-based generation, so array size scales by parameter, runtime array size can be smaller than the physical array, and illegal mappings are reported instead of producing garbage IDs.

---
 rtl/pe_id_scan_gen_if.sv | 51 +++++
 rtl/pe_id_scan_gen.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_pe_id_scan_gen.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_id_scan_gen_if.sv
// ----------------------------------------------------------------------------
// pe_id_scan_gen_if
// Record stream from the PE-array ID generator to the multicast-controller ID
// loader. The master (the generator) drives one PE record per beat. The slave
// (the loader) accepts a beat with id_ready. A beat transfers on
// id_valid && id_ready.
//
// Signals
//   id_valid     master -> slave  record valid
//   id_ready     slave  -> master record accepted
//   id_row       master -> slave  PE row coordinate
//   id_col       master -> slave  PE column coordinate
//   *_xid        master -> slave  X-IDs; all-ones means disabled
//   *_yid        master -> slave  Y-IDs; all-ones means disabled
// ----------------------------------------------------------------------------
interface pe_id_scan_gen_if #(
  parameter int ARRAY_H = 6,
  parameter int ARRAY_W = 8,
  parameter int XID_W   = 5,
  parameter int YID_W   = 3
);
  localparam int ROW_W = $clog2(ARRAY_H);
  localparam int COL_W = $clog2(ARRAY_W);

  logic             id_valid;
  logic             id_ready;
  logic [ROW_W-1:0] id_row;
  logic [COL_W-1:0] id_col;
  logic [XID_W-1:0] filter_xid;
  logic [XID_W-1:0] ifmap_xid;
  logic [XID_W-1:0] ipsum_xid;
  logic [XID_W-1:0] opsum_xid;
  logic [YID_W-1:0] filter_yid;
  logic [YID_W-1:0] ifmap_yid;
  logic [YID_W-1:0] ipsum_yid;
  logic [YID_W-1:0] opsum_yid;

  modport master (
    output id_valid, id_row, id_col,
    output filter_xid, ifmap_xid, ipsum_xid, opsum_xid,
    output filter_yid, ifmap_yid, ipsum_yid, opsum_yid,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_row, id_col,
    input  filter_xid, ifmap_xid, ipsum_xid, opsum_xid,
    input  filter_yid, ifmap_yid, ipsum_yid, opsum_yid,
    output id_ready
  );
endinterface

// File: rtl/pe_id_scan_gen.sv
// ----------------------------------------------------------------------------
// pe_id_scan_gen
// Counter-based PE-array ID generator. On i_start it latches one layer-mapping
// configuration. It checks that the mapping is legal and then walks every
// physical PE in row-major order. It emits one ID record per PE on the m_id
// stream. An illegal mapping ends the request with o_err and emits no records.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           one-cycle request, sampled only while idle
//   i_cfg_h, i_cfg_w  rows/columns of the array in use
//   i_kernel_h, i_r, i_t_h, i_t_w, i_e   convolution mapping parameters
//   i_linear          1 = FC/linear mapping
//   o_busy            high while a request is in progress
//   o_done            one-cycle pulse at the end of a request
//   o_err             illegal configuration; valid with o_done, held until the
//                     next start
//   m_id              record stream (master side)
// ----------------------------------------------------------------------------
module pe_id_scan_gen #(
  parameter int ARRAY_H = 6,
  parameter int ARRAY_W = 8,
  parameter int XID_W   = 5,
  parameter int YID_W   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [$clog2(ARRAY_H+1)-1:0]  i_cfg_h,
  input  logic [$clog2(ARRAY_W+1)-1:0]  i_cfg_w,
  input  logic [3:0]                    i_kernel_h,
  input  logic [3:0]                    i_r,
  input  logic [3:0]                    i_t_h,
  input  logic [3:0]                    i_t_w,
  input  logic [3:0]                    i_e,
  input  logic                          i_linear,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  pe_id_scan_gen_if.master              m_id
);

  localparam int CH_W  = $clog2(ARRAY_H+1);
  localparam int CW_W  = $clog2(ARRAY_W+1);
  localparam int ROW_W = $clog2(ARRAY_H);
  localparam int COL_W = $clog2(ARRAY_W);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_H-1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARRAY_W-1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SCAN, S_DONE} state_t;

  typedef struct packed {
    logic [XID_W-1:0] f_x;
    logic [XID_W-1:0] i_x;
    logic [XID_W-1:0] p_x;
    logic [XID_W-1:0] o_x;
    logic [YID_W-1:0] f_y;
    logic [YID_W-1:0] i_y;
    logic [YID_W-1:0] p_y;
    logic [YID_W-1:0] o_y;
  } rec_t;

  // All IDs disabled: this is the record for an unused PE and the reset value.
  localparam rec_t REC_OFF = '1;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_valid;
  rec_t             r_rec;

  // Latched configuration
  logic [CH_W-1:0]  r_cfg_h;
  logic [CW_W-1:0]  r_cfg_w;
  logic [3:0]       r_kh;
  logic [3:0]       r_r;
  logic [3:0]       r_th;
  logic [3:0]       r_tw;
  logic [3:0]       r_e;
  logic             r_lin;

  // Scan position of the record currently presented, with running mod/div
  // counters: kr = row mod kernel_h, sv = row div kernel_h,
  // oc = col mod e, sh = col div e.
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [3:0]       r_kr;
  logic [3:0]       r_sv;
  logic [3:0]       r_oc;
  logic [4:0]       r_sh;

  // Position of the next record to load (origin while in CHECK)
  logic [ROW_W-1:0] w_nrow;
  logic [COL_W-1:0] w_ncol;
  logic [3:0]       w_nkr;
  logic [3:0]       w_nsv;
  logic [3:0]       w_noc;
  logic [4:0]       w_nsh;

  logic [7:0]       w_conv_h;
  logic [7:0]       w_conv_w;
  logic [7:0]       w_row8;
  logic [7:0]       w_col8;
  logic [XID_W-1:0] w_fold;
  logic [XID_W-1:0] w_ifx;
  logic             w_in_cfg;
  logic             w_bad;
  logic             w_last;
  logic             w_xfer;
  rec_t             w_rec;

  // Footprint of the conv mapping, computed in 8 bits.
  assign w_conv_h = 8'(r_r) * 8'(r_th) * 8'(r_kh);
  assign w_conv_w = 8'(r_tw) * 8'(r_e);

  assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_xfer = r_valid && m_id.id_ready;

  // Legality of the latched configuration
  always_comb begin
    w_bad = (r_cfg_h == '0) || (r_cfg_h > CH_W'(ARRAY_H)) ||
            (r_cfg_w == '0) || (r_cfg_w > CW_W'(ARRAY_W));
    if (!r_lin) begin
      if ((r_kh == 4'd0) || (r_r == 4'd0) || (r_th == 4'd0) ||
          (r_tw == 4'd0) || (r_e == 4'd0))
        w_bad = 1'b1;
      if (w_conv_h > 8'(r_cfg_h))
        w_bad = 1'b1;
      if (w_conv_w > 8'(r_cfg_w))
        w_bad = 1'b1;
    end
  end

  // Next scan position. The mod/div counters step with the position, so no
  // divider is needed. Outside SCAN this is the origin. CHECK uses it to load
  // the first record.
  always_comb begin
    w_nrow = '0;
    w_ncol = '0;
    w_nkr  = '0;
    w_nsv  = '0;
    w_noc  = '0;
    w_nsh  = '0;
    if (r_state == S_SCAN) begin
      if (r_col == LAST_COL) begin
        w_nrow = r_row + 1'b1;
        if (r_kr == r_kh - 4'd1) begin
          w_nkr = '0;
          w_nsv = r_sv + 4'd1;
        end else begin
          w_nkr = r_kr + 4'd1;
          w_nsv = r_sv;
        end
      end else begin
        w_nrow = r_row;
        w_ncol = r_col + 1'b1;
        w_nkr  = r_kr;
        w_nsv  = r_sv;
        if (r_oc == r_e - 4'd1) begin
          w_noc = '0;
          w_nsh = r_sh + 5'd1;
        end else begin
          w_noc = r_oc + 4'd1;
          w_nsh = r_sh;
        end
      end
    end
  end

  // Record for the next position
  always_comb begin
    w_row8   = 8'(w_nrow);
    w_col8   = 8'(w_ncol);
    w_in_cfg = (w_row8 < 8'(r_cfg_h)) && (w_col8 < 8'(r_cfg_w));
    // sh*e + oc reassembles the column index inside the conv footprint.
    w_fold   = XID_W'(8'(w_nsh) * 8'(r_e) + 8'(w_noc));
    w_ifx    = XID_W'(8'(w_nkr) + 8'(w_noc));
    w_rec    = REC_OFF;
    if (r_lin) begin
      if (w_in_cfg) begin
        w_rec.f_x = XID_W'(w_ncol);
        w_rec.f_y = YID_W'(w_nrow);
        w_rec.i_x = '0;
        w_rec.i_y = '0;
        w_rec.p_x = XID_W'(w_ncol);
        w_rec.p_y = YID_W'(w_nrow);
        w_rec.o_x = XID_W'(w_ncol);
        w_rec.o_y = YID_W'(w_nrow);
      end
    end else if (w_in_cfg && (w_row8 < w_conv_h) && (w_col8 < w_conv_w)) begin
      w_rec.f_x = XID_W'(w_nsh);
      w_rec.f_y = YID_W'(w_nrow);
      w_rec.i_x = w_ifx;
      w_rec.i_y = YID_W'(w_nsv);
      // Bottom kernel row takes the incoming psum. The top kernel row emits
      // the outgoing psum.
      w_rec.p_x = (w_nkr == r_kh - 4'd1) ? w_fold : '1;
      w_rec.p_y = YID_W'(w_nsv);
      w_rec.o_x = (w_nkr == 4'd0) ? w_fold : '1;
      w_rec.o_y = YID_W'(w_nsv);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_rec   <= REC_OFF;
      r_cfg_h <= '0;
      r_cfg_w <= '0;
      r_kh    <= '0;
      r_r     <= '0;
      r_th    <= '0;
      r_tw    <= '0;
      r_e     <= '0;
      r_lin   <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_kr    <= '0;
      r_sv    <= '0;
      r_oc    <= '0;
      r_sh    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cfg_h <= i_cfg_h;
            r_cfg_w <= i_cfg_w;
            r_kh    <= i_kernel_h;
            r_r     <= i_r;
            r_th    <= i_t_h;
            r_tw    <= i_t_w;
            r_e     <= i_e;
            r_lin   <= i_linear;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err <= w_bad;
          if (w_bad) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_valid <= 1'b1;
            r_rec   <= w_rec;
            r_row   <= w_nrow;
            r_col   <= w_ncol;
            r_kr    <= w_nkr;
            r_sv    <= w_nsv;
            r_oc    <= w_noc;
            r_sh    <= w_nsh;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // The record only changes on a transfer, so it holds through stalls.
          if (w_xfer) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rec <= w_rec;
              r_row <= w_nrow;
              r_col <= w_ncol;
              r_kr  <= w_nkr;
              r_sv  <= w_nsv;
              r_oc  <= w_noc;
              r_sh  <= w_nsh;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

  assign m_id.id_valid   = r_valid;
  assign m_id.id_row     = r_row;
  assign m_id.id_col     = r_col;
  assign m_id.filter_xid = r_rec.f_x;
  assign m_id.ifmap_xid  = r_rec.i_x;
  assign m_id.ipsum_xid  = r_rec.p_x;
  assign m_id.opsum_xid  = r_rec.o_x;
  assign m_id.filter_yid = r_rec.f_y;
  assign m_id.ifmap_yid  = r_rec.i_y;
  assign m_id.ipsum_yid  = r_rec.p_y;
  assign m_id.opsum_yid  = r_rec.o_y;

endmodule

// File: tb/tb_pe_id_scan_gen.sv
// ----------------------------------------------------------------------------
// tb_pe_id_scan_gen
// Directed bench for pe_id_scan_gen on a 6x8 array. Every request is driven
// at a negedge. The cycle in which start is high is cycle 0. Outputs are
// observed at the negedge of each later cycle k. Captured records are checked
// against hand-computed vectors and a div/mod reference model.
// ----------------------------------------------------------------------------
module tb_pe_id_scan_gen;
  localparam int AH = 6;
  localparam int AW = 8;
  localparam int XW = 5;
  localparam int YW = 3;
  localparam int NB = AH * AW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [2:0] i_cfg_h = '0;
  logic [3:0] i_cfg_w = '0;
  logic [3:0] i_kernel_h = '0, i_r = '0, i_t_h = '0, i_t_w = '0, i_e = '0;
  logic       i_linear = 1'b0;
  logic       o_busy, o_done, o_err;

  pe_id_scan_gen_if #(.ARRAY_H(AH), .ARRAY_W(AW), .XID_W(XW), .YID_W(YW)) u_if ();

  pe_id_scan_gen #(.ARRAY_H(AH), .ARRAY_W(AW), .XID_W(XW), .YID_W(YW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_cfg_h    (i_cfg_h),
    .i_cfg_w    (i_cfg_w),
    .i_kernel_h (i_kernel_h),
    .i_r        (i_r),
    .i_t_h      (i_t_h),
    .i_t_w      (i_t_w),
    .i_e        (i_e),
    .i_linear   (i_linear),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .m_id       (u_if)
  );

  always #5 clk = ~clk;

  typedef struct packed { int h, w, kh, r, th, tw, e, lin; } cfg_t;
  typedef struct packed { int fx, fy, ix, iy, px, py, ox, oy; } rec_t;
  typedef struct packed { int c, row, col; rec_t ex; } vec_t;

  int   checks = 0;
  int   errors = 0;
  cfg_t cfgs[4];
  vec_t vecs[14];
  rec_t cap[NB];
  rec_t unu;

  // Results of the last run
  int beats, first_cyc, done_cyc, err_done, err_c1, busy_c1;
  int order_bad, stall_bad, drop_bad, busy_after, busy_after2;

  function automatic rec_t mk(input int fx, fy, ix, iy, px, py, ox, oy);
    rec_t t;
    t.fx = fx; t.fy = fy; t.ix = ix; t.iy = iy;
    t.px = px; t.py = py; t.ox = ox; t.oy = oy;
    return t;
  endfunction

  function automatic vec_t mv(input int c, row, col, input rec_t ex);
    vec_t v;
    v.c = c; v.row = row; v.col = col; v.ex = ex;
    return v;
  endfunction

  function automatic cfg_t mc(input int h, w, kh, r, th, tw, e, lin);
    cfg_t c;
    c.h = h; c.w = w; c.kh = kh; c.r = r; c.th = th; c.tw = tw; c.e = e; c.lin = lin;
    return c;
  endfunction

  function automatic rec_t cur_rec();
    return mk(int'(u_if.filter_xid), int'(u_if.filter_yid), int'(u_if.ifmap_xid),
              int'(u_if.ifmap_yid), int'(u_if.ipsum_xid), int'(u_if.ipsum_yid),
              int'(u_if.opsum_xid), int'(u_if.opsum_yid));
  endfunction

  // Reference built from plain division/modulo.
  function automatic rec_t model(input cfg_t c, input int row, input int col);
    rec_t m;
    int   kr, sv;
    m = mk(31, 7, 31, 7, 31, 7, 31, 7);
    if (c.lin != 0) begin
      if (row < c.h && col < c.w) m = mk(col, row, 0, 0, col, row, col, row);
    end else if (row < c.h && col < c.w && row < c.r * c.th * c.kh && col < c.tw * c.e) begin
      kr = row % c.kh;
      sv = row / c.kh;
      m = mk(col / c.e, row, kr + col % c.e, sv, (kr == c.kh - 1) ? col : 31, sv,
             (kr == 0) ? col : 31, sv);
    end
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_rec(input string name, input rec_t act, input rec_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%p required=%p", name, act, req);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_err"}, int'(o_err), 0);
    chk({tag, "_valid"}, int'(u_if.id_valid), 0);
    chk({tag, "_rowcol"}, int'(u_if.id_row) * 100 + int'(u_if.id_col), 0);
    chk_rec({tag, "_ids"}, cur_rec(), unu);
  endtask

  // One request: start pulse, then observe until done (bounded).
  task automatic run(input cfg_t c, input bit bp, input int restart_at);
    rec_t held;
    int   held_pos, idx, k;
    bit   stalled;
    beats = 0; first_cyc = -1; done_cyc = -1; err_done = -1; err_c1 = -1; busy_c1 = -1;
    order_bad = 0; stall_bad = 0; drop_bad = 0; stalled = 1'b0; held_pos = 0;
    for (int i = 0; i < NB; i++) cap[i] = mk(-1, -1, -1, -1, -1, -1, -1, -1);
    @(negedge clk);
    i_cfg_h = 3'(c.h); i_cfg_w = 4'(c.w); i_kernel_h = 4'(c.kh); i_r = 4'(c.r);
    i_t_h = 4'(c.th); i_t_w = 4'(c.tw); i_e = 4'(c.e); i_linear = 1'(c.lin);
    i_start = 1'b1;
    u_if.id_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    // Change the configuration inputs after the start so that a design which
    // reads them again would produce wrong records.
    i_cfg_h = 3'd1; i_cfg_w = 4'd1; i_kernel_h = 4'd0; i_e = 4'd15; i_linear = ~i_linear;
    k = 1;
    while (k < 500) begin
      if (k == 1) begin err_c1 = int'(o_err); busy_c1 = int'(o_busy); end
      i_start = (k == restart_at);
      u_if.id_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (u_if.id_valid) begin
        if (first_cyc < 0) first_cyc = k;
        idx = int'(u_if.id_row) * AW + int'(u_if.id_col);
        if (stalled && (cur_rec() !== held || idx != held_pos)) stall_bad++;
        if (u_if.id_ready) begin
          if (idx != beats) order_bad++;
          if (idx < NB) cap[idx] = cur_rec();
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = cur_rec();
          held_pos = idx;
        end
      end else if (stalled) begin
        drop_bad++;
        stalled = 1'b0;
      end
      if (o_done) begin
        done_cyc = k;
        err_done = int'(o_err);
        break;
      end
      @(negedge clk);
      k++;
    end
    i_start = 1'b0;
    @(negedge clk);
    busy_after = int'(o_busy);
    @(negedge clk);
    busy_after2 = int'(o_busy);
  endtask

  task automatic check_model(input cfg_t c, input string tag);
    int bad = 0;
    for (int i = 0; i < NB; i++)
      if (cap[i] !== model(c, i / AW, i % AW)) bad++;
    chk({tag, "_model_beats_bad"}, bad, 0);
  endtask

  task automatic check_vecs(input int ci, input string tag);
    for (int i = 0; i < 14; i++)
      if (vecs[i].c == ci)
        chk_rec($sformatf("%s_vec%0d_r%0dc%0d", tag, i, vecs[i].row, vecs[i].col),
                cap[vecs[i].row * AW + vecs[i].col], vecs[i].ex);
  endtask

  task automatic check_legal(input string tag);
    chk({tag, "_beats"}, beats, NB);
    chk({tag, "_order_bad"}, order_bad, 0);
    chk({tag, "_err_done"}, err_done, 0);
    chk({tag, "_busy_c1"}, busy_c1, 1);
    chk({tag, "_first_cyc"}, first_cyc, 2);
  endtask

  initial begin
    int bad;
    unu = mk(31, 7, 31, 7, 31, 7, 31, 7);
    cfgs[0] = mc(6, 8, 3, 2, 1, 2, 4, 0);  // full conv
    cfgs[1] = mc(6, 8, 3, 1, 1, 1, 4, 0);  // partial use
    cfgs[2] = mc(4, 8, 0, 0, 0, 0, 0, 1);  // linear
    cfgs[3] = mc(6, 8, 3, 2, 1, 2, 5, 0);  // t_w*e = 10 > 8
    vecs[0]  = mv(0, 0, 5, mk(1, 0, 1, 0, 31, 0, 5, 0));
    vecs[1]  = mv(0, 2, 3, mk(0, 2, 5, 0, 3, 0, 31, 0));
    vecs[2]  = mv(0, 5, 7, mk(1, 5, 5, 1, 7, 1, 31, 1));
    vecs[3]  = mv(0, 0, 0, mk(0, 0, 0, 0, 31, 0, 0, 0));
    vecs[4]  = mv(0, 3, 4, mk(1, 3, 0, 1, 31, 1, 4, 1));
    vecs[5]  = mv(1, 1, 2, mk(0, 1, 3, 0, 31, 0, 31, 0));
    vecs[6]  = mv(1, 2, 3, mk(0, 2, 5, 0, 3, 0, 31, 0));
    vecs[7]  = mv(1, 3, 0, unu);
    vecs[8]  = mv(1, 0, 4, unu);
    vecs[9]  = mv(2, 3, 6, mk(6, 3, 0, 0, 6, 3, 6, 3));
    vecs[10] = mv(2, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs[11] = mv(2, 4, 2, unu);
    vecs[12] = mv(2, 5, 7, unu);
    vecs[13] = mv(1, 0, 0, mk(0, 0, 0, 0, 31, 0, 0, 0));
    u_if.id_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Conv mapping with continuous ready
    run(cfgs[0], 1'b0, -1);
    check_legal("conv");
    chk("conv_done_cyc", done_cyc, 50);
    chk("conv_busy_after_done", busy_after, 0);
    check_vecs(0, "conv");
    check_model(cfgs[0], "conv");

    // Backpressure
    run(cfgs[0], 1'b1, -1);
    check_legal("bp");
    chk("bp_stall_change", stall_bad, 0);
    chk("bp_valid_drop", drop_bad, 0);
    check_model(cfgs[0], "bp");

    // Partial use
    run(cfgs[1], 1'b0, -1);
    check_legal("part");
    chk("part_done_cyc", done_cyc, 50);
    check_vecs(1, "part");
    bad = 0;
    for (int i = 0; i < NB; i++)
      if ((i / AW >= 3 || i % AW >= 4) && cap[i] !== unu) bad++;
    chk("part_unused_region_bad", bad, 0);
    check_model(cfgs[1], "part");

    // Illegal configuration
    run(cfgs[3], 1'b0, -1);
    chk("ill_beats", beats, 0);
    chk("ill_first_valid", first_cyc, -1);
    chk("ill_done_cyc", done_cyc, 2);
    chk("ill_err", err_done, 1);
    chk("ill_err_held", int'(o_err), 1);

    // Next legal start clears err
    run(cfgs[0], 1'b0, -1);
    chk("clr_err_c1", err_c1, 0);
    check_legal("clr");

    // Linear mapping
    run(cfgs[2], 1'b0, -1);
    check_legal("lin");
    chk("lin_done_cyc", done_cyc, 50);
    check_vecs(2, "lin");
    bad = 0;
    for (int i = 4 * AW; i < NB; i++)
      if (cap[i] !== unu) bad++;
    chk("lin_rows45_unused_bad", bad, 0);
    check_model(cfgs[2], "lin");

    // Start pulsed during SCAN is ignored and not queued
    run(cfgs[0], 1'b0, 10);
    chk("restart_beats", beats, NB);
    chk("restart_done_cyc", done_cyc, 50);
    chk("restart_busy_after", busy_after, 0);
    chk("restart_busy_after2", busy_after2, 0);

    // Asynchronous reset at beat 20
    @(negedge clk);
    i_cfg_h = 3'd6; i_cfg_w = 4'd8; i_kernel_h = 4'd3; i_r = 4'd2; i_t_h = 4'd1;
    i_t_w = 4'd2; i_e = 4'd4; i_linear = 1'b0; i_start = 1'b1; u_if.id_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    beats = 0;
    for (int k = 0; k < 200 && beats < 20; k++) begin
      @(negedge clk);
      if (u_if.id_valid && u_if.id_ready) beats++;
    end
    chk("rst_reached_beat20", beats, 20);
    chk("rst_busy_before", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_stays_idle", int'(o_busy) + int'(u_if.id_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
